vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator; next generation of the fixed 640x480 controller.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_pos_counter.sv | 50 +++++
 rtl/vga_timing_gen.sv | 158 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants, sizing helpers and sync polarity type for the VGA timing generator.
package vga_timing_pkg;

    // Default 640x480@60 raster, 25 MHz pixel rate.
    localparam int unsigned DEF_H_PIXELS   = 640;
    localparam int unsigned DEF_H_FRONT    = 16;
    localparam int unsigned DEF_H_SYNC     = 96;
    localparam int unsigned DEF_H_BACK     = 48;
    localparam int unsigned DEF_V_PIXELS   = 480;
    localparam int unsigned DEF_V_FRONT    = 10;
    localparam int unsigned DEF_V_SYNC     = 2;
    localparam int unsigned DEF_V_BACK     = 33;
    localparam int unsigned DEF_PIX_DIV    = 1;
    localparam int unsigned DEF_FETCH_LEAD = 2;
    localparam int unsigned DEF_CNT_W      = 10;
    localparam int unsigned MAX_PIX_DIV    = 16;
    localparam int unsigned FRAME_CNT_W    = 16;

    // Active level of a sync output.
    typedef enum logic {
        POL_LOW  = 1'b0,
        POL_HIGH = 1'b1
    } sync_pol_e;

    // Pixel ticks per line.
    function automatic int unsigned h_total(input int unsigned pixels, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return pixels + front + sync + back;
    endfunction

    // Lines per frame.
    function automatic int unsigned v_total(input int unsigned pixels, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return pixels + front + sync + back;
    endfunction

    // Larger of two sizes.
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_pos_counter.sv
// Raster x/y wrap counter with a parameterised load value; also exposes its next position.
module vga_pos_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL = h_total(DEF_H_PIXELS, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK),
    parameter int unsigned V_TOTAL = v_total(DEF_V_PIXELS, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK),
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned LOAD_X  = H_TOTAL - 1,
    parameter int unsigned LOAD_Y  = V_TOTAL - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic [CNT_W-1:0] next_x_c,
    output logic [CNT_W-1:0] next_y_c
);

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_LOAD = CNT_W'(LOAD_X);
    localparam logic [CNT_W-1:0] Y_LOAD = CNT_W'(LOAD_Y);

    // Next position: x wraps at end of line, y steps only on an x wrap.
    always_comb begin
        next_x_c = x;
        next_y_c = y;
        if (tick) begin
            if (x == X_LAST) begin
                next_x_c = '0;
                next_y_c = (y == Y_LAST) ? '0 : y + CNT_W'(1);
            end else begin
                next_x_c = x + CNT_W'(1);
            end
        end
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (reset) begin
            x <= X_LOAD;
            y <= Y_LOAD;
        end else begin
            x <= next_x_c;
            y <= next_y_c;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with clock-enable divider, strobes,
// frame counter and a leading fetch coordinate for pipelined pixel memories.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_PIXELS   = DEF_H_PIXELS,
    parameter int unsigned H_FRONT    = DEF_H_FRONT,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BACK     = DEF_H_BACK,
    parameter int unsigned V_PIXELS   = DEF_V_PIXELS,
    parameter int unsigned V_FRONT    = DEF_V_FRONT,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BACK     = DEF_V_BACK,
    parameter sync_pol_e   HS_POL     = POL_LOW,
    parameter sync_pol_e   VS_POL     = POL_LOW,
    parameter int unsigned PIX_DIV    = DEF_PIX_DIV,
    parameter int unsigned FETCH_LEAD = DEF_FETCH_LEAD,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    output logic                   pix_tick,
    output logic [CNT_W-1:0]       x_vga,
    output logic [CNT_W-1:0]       y_vga,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   flow_enabled,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0]       fetch_x,
    output logic [CNT_W-1:0]       fetch_y,
    output logic                   fetch_valid
);

    localparam int unsigned H_TOTAL = h_total(H_PIXELS, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = v_total(V_PIXELS, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_PIXELS);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_PIXELS);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_PIXELS + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_PIXELS + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_PIXELS + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_PIXELS + V_FRONT + V_SYNC);

    localparam logic HS_ACT = 1'(HS_POL);
    localparam logic VS_ACT = 1'(VS_POL);

    // Fetch counter resets one tick short of its lead past (0,0), so the first
    // tick after reset lands it exactly FETCH_LEAD ticks ahead of the display.
    localparam int unsigned FETCH_RST_X     = (FETCH_LEAD == 0) ? H_TOTAL - 1 : FETCH_LEAD - 1;
    localparam int unsigned FETCH_RST_Y     = (FETCH_LEAD == 0) ? V_TOTAL - 1 : 0;
    localparam logic        FETCH_RST_VALID = (FETCH_RST_X < H_PIXELS) && (FETCH_RST_Y < V_PIXELS);

    localparam int unsigned      DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    // Reject parameter sets the counters cannot represent.
    if (FETCH_LEAD >= H_TOTAL) begin : g_bad_lead
        $error("vga_timing_gen: FETCH_LEAD must be below H_TOTAL");
    end
    if ((PIX_DIV < 1) || (PIX_DIV > MAX_PIX_DIV)) begin : g_bad_div
        $error("vga_timing_gen: PIX_DIV must be within 1..16");
    end
    if ((64'(1) << CNT_W) <= 64'(max2(H_TOTAL, V_TOTAL))) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] disp_nx_c;
    logic [CNT_W-1:0] disp_ny_c;
    logic [CNT_W-1:0] fetch_nx_c;
    logic [CNT_W-1:0] fetch_ny_c;

    // Position lies inside the visible window.
    function automatic logic is_visible(input logic [CNT_W-1:0] px, input logic [CNT_W-1:0] py);
        return (px < H_VIS) && (py < V_VIS);
    endfunction

    // Horizontal sync window test.
    function automatic logic in_hsync(input logic [CNT_W-1:0] px);
        return (px >= HS_START) && (px < HS_END);
    endfunction

    // Vertical sync window test.
    function automatic logic in_vsync(input logic [CNT_W-1:0] py);
        return (py >= VS_START) && (py < VS_END);
    endfunction

    // Pixel-rate divider; frozen while en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // Tick is gated by reset so a pending tick never competes with a reset.
    assign pix_tick = en && !reset && (div_cnt == DIV_LAST);

    vga_pos_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .CNT_W   (CNT_W),
        .LOAD_X  (H_TOTAL - 1),
        .LOAD_Y  (V_TOTAL - 1)
    ) u_disp_cnt (
        .clk      (clk),
        .reset    (reset),
        .tick     (pix_tick),
        .x        (x_vga),
        .y        (y_vga),
        .next_x_c (disp_nx_c),
        .next_y_c (disp_ny_c)
    );

    vga_pos_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .CNT_W   (CNT_W),
        .LOAD_X  (FETCH_RST_X),
        .LOAD_Y  (FETCH_RST_Y)
    ) u_fetch_cnt (
        .clk      (clk),
        .reset    (reset),
        .tick     (pix_tick),
        .x        (fetch_x),
        .y        (fetch_y),
        .next_x_c (fetch_nx_c),
        .next_y_c (fetch_ny_c)
    );

    // Flags and strobes decoded from the next position so they align with x_vga/y_vga.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync        <= ~HS_ACT;
            vsync        <= ~VS_ACT;
            flow_enabled <= 1'b0;
            fetch_valid  <= FETCH_RST_VALID;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            frame_count  <= '0;
        end else begin
            hsync        <= in_hsync(disp_nx_c) ? HS_ACT : ~HS_ACT;
            vsync        <= in_vsync(disp_ny_c) ? VS_ACT : ~VS_ACT;
            flow_enabled <= is_visible(disp_nx_c, disp_ny_c);
            fetch_valid  <= is_visible(fetch_nx_c, fetch_ny_c);
            line_start   <= pix_tick && (disp_nx_c == '0);
            frame_start  <= pix_tick && (disp_nx_c == '0) && (disp_ny_c == '0);
            if (pix_tick && (disp_nx_c == '0) && (disp_ny_c == '0)) begin
                frame_count <= frame_count + FRAME_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing, divide-by-2 pixel clock, and a tiny
// active-high raster for full-frame, sync window and mid-frame reset checks.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults, PIX_DIV=1, FETCH_LEAD=2
    logic        reset_a, en_a;
    logic        a_tick, a_hs, a_vs, a_flow, a_ls, a_fs, a_fv;
    logic [9:0]  a_x, a_y, a_fx, a_fy;
    logic [15:0] a_fc;

    // Instance B: defaults with PIX_DIV=2
    logic        en_b;
    logic        b_tick, b_hs, b_vs, b_flow, b_ls, b_fs, b_fv;
    logic [9:0]  b_x, b_y, b_fx, b_fy;
    logic [15:0] b_fc;

    // Instance C: tiny raster, active-high syncs, FETCH_LEAD=3, CNT_W=4
    logic        reset_c, en_c;
    logic        c_tick, c_hs, c_vs, c_flow, c_ls, c_fs, c_fv;
    logic [3:0]  c_x, c_y, c_fx, c_fy;
    logic [15:0] c_fc;

    vga_timing_gen #(.PIX_DIV(1), .FETCH_LEAD(2)) u_a (
        .clk(clk), .reset(reset_a), .en(en_a), .pix_tick(a_tick),
        .x_vga(a_x), .y_vga(a_y), .hsync(a_hs), .vsync(a_vs),
        .flow_enabled(a_flow), .line_start(a_ls), .frame_start(a_fs),
        .frame_count(a_fc), .fetch_x(a_fx), .fetch_y(a_fy), .fetch_valid(a_fv)
    );

    vga_timing_gen #(.PIX_DIV(2)) u_b (
        .clk(clk), .reset(reset_a), .en(en_b), .pix_tick(b_tick),
        .x_vga(b_x), .y_vga(b_y), .hsync(b_hs), .vsync(b_vs),
        .flow_enabled(b_flow), .line_start(b_ls), .frame_start(b_fs),
        .frame_count(b_fc), .fetch_x(b_fx), .fetch_y(b_fy), .fetch_valid(b_fv)
    );

    vga_timing_gen #(
        .H_PIXELS(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_PIXELS(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(POL_HIGH), .VS_POL(POL_HIGH),
        .PIX_DIV(1), .FETCH_LEAD(3), .CNT_W(4)
    ) u_c (
        .clk(clk), .reset(reset_c), .en(en_c), .pix_tick(c_tick),
        .x_vga(c_x), .y_vga(c_y), .hsync(c_hs), .vsync(c_vs),
        .flow_enabled(c_flow), .line_start(c_ls), .frame_start(c_fs),
        .frame_count(c_fc), .fetch_x(c_fx), .fetch_y(c_fy), .fetch_valid(c_fv)
    );

    // One comparison: counts it and reports a mismatch.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_a = 1'b1; en_a = 1'b1; en_b = 1'b1;
        reset_c = 1'b1; en_c = 1'b1;
        step(3);

        // Reset state
        chk("a_rst_x", 32'(a_x), 799);
        chk("a_rst_y", 32'(a_y), 524);
        chk("a_rst_hs", 32'(a_hs), 1);
        chk("a_rst_vs", 32'(a_vs), 1);
        chk("a_rst_flow", 32'(a_flow), 0);
        chk("a_rst_tick", 32'(a_tick), 0);
        chk("a_rst_fc", 32'(a_fc), 0);
        chk("a_rst_fs", 32'(a_fs), 0);
        chk("a_rst_ls", 32'(a_ls), 0);
        chk("a_rst_fx", 32'(a_fx), 1);
        chk("a_rst_fy", 32'(a_fy), 0);
        chk("a_rst_fv", 32'(a_fv), 1);
        chk("b_rst_x", 32'(b_x), 799);
        chk("b_rst_tick", 32'(b_tick), 0);
        chk("c_rst_x", 32'(c_x), 13);
        chk("c_rst_y", 32'(c_y), 6);
        chk("c_rst_hs", 32'(c_hs), 0);
        chk("c_rst_vs", 32'(c_vs), 0);
        chk("c_rst_flow", 32'(c_flow), 0);
        chk("c_rst_fx", 32'(c_fx), 2);
        chk("c_rst_fv", 32'(c_fv), 1);

        // Reset release: first tick lands on (0,0) with strobes
        reset_a = 1'b0;
        step(1);
        chk("a_e1_x", 32'(a_x), 0);
        chk("a_e1_y", 32'(a_y), 0);
        chk("a_e1_fs", 32'(a_fs), 1);
        chk("a_e1_ls", 32'(a_ls), 1);
        chk("a_e1_fc", 32'(a_fc), 1);
        chk("a_e1_flow", 32'(a_flow), 1);
        chk("a_e1_fx", 32'(a_fx), 2);
        chk("a_e1_fv", 32'(a_fv), 1);
        chk("a_e1_hs", 32'(a_hs), 1);
        chk("b_e1_x", 32'(b_x), 799);
        chk("b_e1_tick", 32'(b_tick), 1);
        chk("b_e1_fs", 32'(b_fs), 0);
        step(1);
        chk("a_e2_x", 32'(a_x), 1);
        chk("a_e2_fs", 32'(a_fs), 0);
        chk("a_e2_ls", 32'(a_ls), 0);
        chk("a_e2_fc", 32'(a_fc), 1);
        chk("b_e2_x", 32'(b_x), 0);
        chk("b_e2_fs", 32'(b_fs), 1);
        chk("b_e2_ls", 32'(b_ls), 1);
        chk("b_e2_fc", 32'(b_fc), 1);
        chk("b_e2_tick", 32'(b_tick), 0);

        // Visible edge and hsync window on line 0
        step(638);
        chk("a_x639", 32'(a_x), 639);
        chk("a_flow639", 32'(a_flow), 1);
        step(1);
        chk("a_flow640", 32'(a_flow), 0);
        step(15);
        chk("a_x655", 32'(a_x), 655);
        chk("a_hs655", 32'(a_hs), 1);
        step(1);
        chk("a_hs656", 32'(a_hs), 0);
        step(95);
        chk("a_x751", 32'(a_x), 751);
        chk("a_hs751", 32'(a_hs), 0);
        step(1);
        chk("a_hs752", 32'(a_hs), 1);

        // Divide-by-2: one position per two clocks
        chk("b_x375", 32'(b_x), 375);
        chk("b_tick_hi", 32'(b_tick), 1);
        step(1);
        chk("b_x376", 32'(b_x), 376);
        chk("b_tick_lo", 32'(b_tick), 0);

        // Fetch lead crossing a line boundary
        step(45);
        chk("a_x798", 32'(a_x), 798);
        chk("a_lw_fx", 32'(a_fx), 0);
        chk("a_lw_fy", 32'(a_fy), 1);
        chk("a_lw_fv", 32'(a_fv), 1);
        step(1);
        chk("a_x799_fx", 32'(a_fx), 1);
        chk("a_x799_fy", 32'(a_fy), 1);
        step(1);
        chk("a_l1_x", 32'(a_x), 0);
        chk("a_l1_y", 32'(a_y), 1);
        chk("a_l1_ls", 32'(a_ls), 1);
        chk("a_l1_fs", 32'(a_fs), 0);

        // en low for 37 clocks at x=300
        step(300);
        chk("a_pre_x", 32'(a_x), 300);
        en_a = 1'b0;
        #1;
        chk("a_en0_tick", 32'(a_tick), 0);
        step(37);
        chk("a_frz_x", 32'(a_x), 300);
        chk("a_frz_y", 32'(a_y), 1);
        chk("a_frz_tick", 32'(a_tick), 0);
        chk("a_frz_ls", 32'(a_ls), 0);
        chk("a_frz_fx", 32'(a_fx), 302);
        chk("a_frz_hs", 32'(a_hs), 1);
        chk("a_frz_flow", 32'(a_flow), 1);
        en_a = 1'b1;
        #1;
        chk("a_en1_tick", 32'(a_tick), 1);
        step(1);
        chk("a_res_x", 32'(a_x), 301);
        chk("a_res_fx", 32'(a_fx), 303);

        // Fetch lead crossing into line 6
        step(3697);
        chk("a_l5_x", 32'(a_x), 798);
        chk("a_l5_y", 32'(a_y), 5);
        chk("a_l5_fx", 32'(a_fx), 0);
        chk("a_l5_fy", 32'(a_fy), 6);
        chk("a_l5_fv", 32'(a_fv), 1);
        chk("a_l5_flow", 32'(a_flow), 0);
        chk("a_l5_vs", 32'(a_vs), 1);
        chk("a_l5_fc", 32'(a_fc), 1);

        // Tiny raster: release reset
        reset_c = 1'b0;
        step(1);
        chk("c_f1_x", 32'(c_x), 0);
        chk("c_f1_y", 32'(c_y), 0);
        chk("c_f1_fs", 32'(c_fs), 1);
        chk("c_f1_fc", 32'(c_fc), 1);
        chk("c_f1_flow", 32'(c_flow), 1);
        chk("c_f1_fx", 32'(c_fx), 3);
        chk("c_f1_hs", 32'(c_hs), 0);
        step(5);
        chk("c_x5", 32'(c_x), 5);
        chk("c_x5_fx", 32'(c_fx), 8);
        chk("c_x5_fv", 32'(c_fv), 0);
        step(2);
        chk("c_flow7", 32'(c_flow), 1);
        step(1);
        chk("c_flow8", 32'(c_flow), 0);
        step(1);
        chk("c_hs9", 32'(c_hs), 0);
        step(1);
        chk("c_hs10", 32'(c_hs), 1);
        step(1);
        chk("c_hs11", 32'(c_hs), 1);
        step(1);
        chk("c_hs12", 32'(c_hs), 0);

        // Tiny raster: vsync window on line 5
        step(57);
        chk("c_y4_x", 32'(c_x), 13);
        chk("c_vs4", 32'(c_vs), 0);
        step(1);
        chk("c_y5", 32'(c_y), 5);
        chk("c_vs5", 32'(c_vs), 1);
        chk("c_ls5", 32'(c_ls), 1);
        step(13);
        chk("c_vs5_end", 32'(c_vs), 1);
        step(1);
        chk("c_vs6", 32'(c_vs), 0);

        // Tiny raster: fetch frame wrap and second frame_start after 98 ticks
        step(11);
        chk("c_fw_x", 32'(c_x), 11);
        chk("c_fw_fx", 32'(c_fx), 0);
        chk("c_fw_fy", 32'(c_fy), 0);
        chk("c_fw_fv", 32'(c_fv), 1);
        step(2);
        chk("c_pre_fs", 32'(c_fs), 0);
        chk("c_pre_fc", 32'(c_fc), 1);
        step(1);
        chk("c_f2_x", 32'(c_x), 0);
        chk("c_f2_y", 32'(c_y), 0);
        chk("c_f2_fs", 32'(c_fs), 1);
        chk("c_f2_fc", 32'(c_fc), 2);

        // Tiny raster: reset mid-frame
        step(20);
        chk("c_mid_x", 32'(c_x), 6);
        chk("c_mid_y", 32'(c_y), 1);
        reset_c = 1'b1;
        step(1);
        chk("c_mr_x", 32'(c_x), 13);
        chk("c_mr_y", 32'(c_y), 6);
        chk("c_mr_fc", 32'(c_fc), 0);
        chk("c_mr_fs", 32'(c_fs), 0);
        chk("c_mr_ls", 32'(c_ls), 0);
        chk("c_mr_flow", 32'(c_flow), 0);
        chk("c_mr_hs", 32'(c_hs), 0);
        chk("c_mr_fx", 32'(c_fx), 2);
        chk("c_mr_fy", 32'(c_fy), 0);
        chk("c_mr_fv", 32'(c_fv), 1);
        chk("c_mr_tick", 32'(c_tick), 0);
        reset_c = 1'b0;
        step(1);
        chk("c_rr_x", 32'(c_x), 0);
        chk("c_rr_y", 32'(c_y), 0);
        chk("c_rr_fs", 32'(c_fs), 1);
        chk("c_rr_fc", 32'(c_fc), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
